// File: rtl/mig1_fetch_if.sv
// Fetch-unit bus bundle: SimRAM read port, decode-side instruction stream and the
// redirect request from the branch/jump logic.
interface mig1_fetch_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  redirect_en;
   logic [ADDR_WIDTH-3:0] redirect_addr;

   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // insn handshake: a word transfers on any clock edge where insn_valid && insn_ready
   // are both high. While insn_valid is high and no transfer happens, insn_data and
   // insn_pc hold their values. insn_valid never depends on insn_ready.
   logic                  insn_valid;
   logic                  insn_ready;
   logic [DATA_WIDTH-1:0] insn_data;
   logic [ADDR_WIDTH-1:0] insn_pc;

   modport master (
      input  redirect_en, redirect_addr, mem_rd_data, insn_ready,
      output mem_rd_en, mem_rd_addr, insn_valid, insn_data, insn_pc
   );

   modport slave (
      output redirect_en, redirect_addr, mem_rd_data, insn_ready,
      input  mem_rd_en, mem_rd_addr, insn_valid, insn_data, insn_pc
   );
endinterface

// File: rtl/mig1_fetch_unit.sv
// Mig1 instruction fetch: owns the fetch PC, issues 1-cycle-latency RAM reads against
// a credit of free prefetch FIFO slots, and streams buffered words to decode.
module mig1_fetch_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ADDR_WIDTH-3:0] i_rst_addr,
   output logic [ADDR_WIDTH-1:0] o_fetch_pc,
   mig1_fetch_if.master          bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_pc_loaded;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_fetch_pc;

   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_inflight_pc;

   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [CNT_W-1:0]      w_credit_nxt;

   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;

   // Until the first edge after reset the PC follows i_rst_addr, so it tracks the pin
   // while reset is held without needing a non-constant async reset value.
   assign w_fetch_pc = r_pc_loaded ? r_pc : {i_rst_addr, 2'b00};
   assign w_valid    = (r_count != '0);

   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_count_nxt  = r_count;
      w_credit_nxt = '0;

      // STALL is exactly "count + inflight == FIFO_DEPTH", so it doubles as the credit check.
      w_issue = i_rst_n && !bus.redirect_en && (r_state != ST_STALL);
      w_push  = r_inflight && !bus.redirect_en;
      w_pop   = w_valid && bus.insn_ready;

      if (bus.redirect_en) begin
         w_count_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
         endcase
      end

      w_credit_nxt = w_count_nxt + CNT_W'(w_issue);

      if (bus.redirect_en) begin
         w_state_nxt = ST_FLUSH;
      end else if (w_credit_nxt == CNT_W'(FIFO_DEPTH)) begin
         w_state_nxt = ST_STALL;
      end else begin
         w_state_nxt = ST_RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_RESET;
         r_pc_loaded   <= 1'b0;
         r_pc          <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc_loaded <= 1'b1;
         r_count     <= w_count_nxt;
         r_inflight  <= w_issue;

         if (bus.redirect_en) begin
            r_pc <= {bus.redirect_addr, 2'b00};
         end else if (w_issue) begin
            r_pc <= w_fetch_pc + ADDR_WIDTH'(4);
         end else begin
            r_pc <= w_fetch_pc;
         end

         if (w_issue) begin
            r_inflight_pc <= w_fetch_pc;
         end

         // A pop in the redirect cycle still completes; the flush just drops the rest.
         if (bus.redirect_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= bus.mem_rd_data;
         r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
      end
   end

   assign bus.mem_rd_en   = w_issue;
   assign bus.mem_rd_addr = w_fetch_pc;
   assign bus.insn_valid  = w_valid;
   assign bus.insn_data   = w_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign bus.insn_pc     = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
   assign o_fetch_pc      = w_fetch_pc;

endmodule

// File: tb/tb_mig1_fetch_unit.sv
// Bench for mig1_fetch_unit: per-cycle vector table for stream/backpressure/wrap/redirect,
// plus hand sequences for redirect-with-pop, back-to-back redirects and async reset.
module tb_mig1_fetch_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] rst_addr;
   logic [7:0] fetch_pc;

   int n_checks;
   int n_errors;

   logic [7:0]  got_pc_q[$];
   logic [31:0] got_d_q[$];
   logic [7:0]  exp_q[$];

   mig1_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   mig1_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rst_addr (rst_addr),
      .o_fetch_pc (fetch_pc),
      .bus        (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // SimRAM model: each word holds a tag of its own byte address.
   function automatic logic [31:0] ram_word(input logic [7:0] a);
      return 32'hC0DE_0000 | {24'h0, a};
   endfunction

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= ram_word(bus.mem_rd_addr);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rn, input logic rdy, input logic rd, input logic [5:0] ra);
      @(negedge clk);
      rst_n             = rn;
      bus.insn_ready    = rdy;
      bus.redirect_en   = rd;
      bus.redirect_addr = ra;
      #1;
      if (rst_n && bus.insn_valid && bus.insn_ready) begin
         got_pc_q.push_back(bus.insn_pc);
         got_d_q.push_back(bus.insn_data);
      end
   endtask

   task automatic check_stream(input string name);
      chk({name, " count"}, 32'(got_pc_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_pc_q.size(); i++) begin
         chk($sformatf("%s pc%0d", name, i), 32'(got_pc_q[i]), 32'(exp_q[i]));
         chk($sformatf("%s data%0d", name, i), got_d_q[i], ram_word(exp_q[i]));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic       rst_n;
      logic [5:0] ra;
      logic       rdy;
      logic       redir;
      logic [5:0] rda;
      logic       e_en;
      logic [7:0] e_addr;
      logic       e_v;
      logic [7:0] e_pc;
      logic [7:0] e_fpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rn, input logic [5:0] ra, input logic rdy,
                              input logic rd, input logic [5:0] rda, input logic e_en,
                              input logic [7:0] e_addr, input logic e_v,
                              input logic [7:0] e_pc, input logic [7:0] e_fpc);
      vec_t t;
      t = '{rn, ra, rdy, rd, rda, e_en, e_addr, e_v, e_pc, e_fpc};
      return t;
   endfunction

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      rst_n             = 1'b0;
      rst_addr          = 6'h10;
      bus.insn_ready    = 1'b0;
      bus.redirect_en   = 1'b0;
      bus.redirect_addr = '0;

      // stream from 0x40 with decode always ready
      tbl.push_back(v(0, 6'h10, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h40, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h44, 0, 8'h00, 8'h44));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h48, 1, 8'h40, 8'h48));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h4C, 1, 8'h44, 8'h4C));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h50, 1, 8'h48, 8'h50));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h54, 1, 8'h4C, 8'h54));
      // backpressure from reset: four reads, stall, then drain and resume at 0x50
      tbl.push_back(v(0, 6'h10, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h40, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h44, 0, 8'h00, 8'h44));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h48, 1, 8'h40, 8'h48));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h4C, 1, 8'h40, 8'h4C));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 0, 8'h00, 1, 8'h40, 8'h50));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 0, 8'h00, 1, 8'h40, 8'h50));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 0, 8'h00, 1, 8'h40, 8'h50));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h50, 1, 8'h44, 8'h50));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h54, 1, 8'h48, 8'h54));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h58, 1, 8'h4C, 8'h58));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h5C, 1, 8'h50, 8'h5C));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h60, 1, 8'h54, 8'h60));
      // address wrap 0xFC -> 0x00
      tbl.push_back(v(0, 6'h3E, 1, 0, 6'h00, 0, 8'h00, 0, 8'h00, 8'hF8));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'hF8, 0, 8'h00, 8'hF8));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'hFC, 0, 8'h00, 8'hFC));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'h00, 1, 8'hF8, 8'h00));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'h04, 1, 8'hFC, 8'h04));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'h08, 1, 8'h00, 8'h08));
      tbl.push_back(v(1, 6'h3E, 1, 0, 6'h00, 1, 8'h0C, 1, 8'h04, 8'h0C));
      // redirect to 0x20 while three entries are buffered and one is in flight
      tbl.push_back(v(0, 6'h10, 0, 0, 6'h00, 0, 8'h00, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h40, 0, 8'h00, 8'h40));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h44, 0, 8'h00, 8'h44));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h48, 1, 8'h40, 8'h48));
      tbl.push_back(v(1, 6'h10, 0, 0, 6'h00, 1, 8'h4C, 1, 8'h40, 8'h4C));
      tbl.push_back(v(1, 6'h10, 0, 1, 6'h08, 0, 8'h00, 1, 8'h40, 8'h50));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h20, 0, 8'h00, 8'h20));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h24, 0, 8'h00, 8'h24));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h28, 1, 8'h20, 8'h28));
      tbl.push_back(v(1, 6'h10, 1, 0, 6'h00, 1, 8'h2C, 1, 8'h24, 8'h2C));

      foreach (tbl[i]) begin
         rst_addr = tbl[i].ra;
         step(tbl[i].rst_n, tbl[i].rdy, tbl[i].redir, tbl[i].rda);
         chk($sformatf("v%0d rd_en", i), 32'(bus.mem_rd_en), 32'(tbl[i].e_en));
         if (tbl[i].e_en)
            chk($sformatf("v%0d rd_addr", i), 32'(bus.mem_rd_addr), 32'(tbl[i].e_addr));
         chk($sformatf("v%0d valid", i), 32'(bus.insn_valid), 32'(tbl[i].e_v));
         if (tbl[i].e_v) begin
            chk($sformatf("v%0d pc", i), 32'(bus.insn_pc), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d data", i), bus.insn_data, ram_word(tbl[i].e_pc));
         end
         if (!tbl[i].rst_n) begin
            chk($sformatf("v%0d rst pc", i), 32'(bus.insn_pc), 32'h0);
            chk($sformatf("v%0d rst data", i), bus.insn_data, 32'h0);
         end
         chk($sformatf("v%0d fetch_pc", i), 32'(fetch_pc), 32'(tbl[i].e_fpc));
      end

      // ---- redirect with a same-cycle pop, then back-to-back redirects ----
      rst_addr = 6'h10;
      step(0, 1, 0, 6'h00);
      got_pc_q.delete(); got_d_q.delete();
      repeat (3) step(1, 1, 0, 6'h00);
      step(1, 1, 1, 6'h30);
      chk("redir_pop rd_en", 32'(bus.mem_rd_en), 32'h0);
      repeat (2) step(1, 1, 0, 6'h00);
      step(1, 1, 1, 6'h08);
      step(1, 1, 1, 6'h38);
      repeat (6) step(1, 1, 0, 6'h00);
      exp_q = '{8'h40, 8'h44, 8'hC0, 8'hE0, 8'hE4, 8'hE8, 8'hEC};
      check_stream("redir_seq");

      // ---- asynchronous reset between edges with a read in flight ----
      step(0, 1, 0, 6'h00);
      repeat (5) step(1, 1, 0, 6'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset rd_en", 32'(bus.mem_rd_en), 32'h0);
      chk("areset valid", 32'(bus.insn_valid), 32'h0);
      chk("areset pc", 32'(bus.insn_pc), 32'h0);
      chk("areset data", bus.insn_data, 32'h0);
      chk("areset fetch_pc", 32'(fetch_pc), 32'h40);
      rst_addr = 6'h20;
      #1;
      chk("areset track", 32'(fetch_pc), 32'h80);
      got_pc_q.delete(); got_d_q.delete();
      step(1, 1, 0, 6'h00);
      chk("restart rd_en", 32'(bus.mem_rd_en), 32'h1);
      chk("restart rd_addr", 32'(bus.mem_rd_addr), 32'h80);
      repeat (5) step(1, 1, 0, 6'h00);
      exp_q = '{8'h80, 8'h84, 8'h88, 8'h8C};
      check_stream("areset_seq");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
